// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared FSM state type and default sizing for the
// scheduled clock divider.
`timescale 1ns/1ps
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int NW_DEF      = 4;
    localparam int NUM_REQ_DEF = 2;
    localparam int PCNT_W      = 16;

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter and registered divided clock.
// Holds the applied N; a load restarts the period at cnt=0.
`timescale 1ns/1ps
module clk_div_core #(
    parameter int NW = 4
) (
    input  logic          i_clk,
    input  logic          rst,
    input  logic          load,
    input  logic [NW-1:0] load_n,
    input  logic          run,
    output logic          out_clk,
    output logic          boundary,
    output logic [NW-1:0] cur_n
);

    logic [NW:0]   cnt_q, cnt_d, last;
    logic [NW-1:0] n_q, n_d;
    logic          out_q, out_d;

    // Last count of the period and next counter / clock values.
    always_comb begin
        last     = {n_q, 1'b0} - {{NW{1'b0}}, 1'b1};
        boundary = run && (cnt_q == last);
        n_d      = load ? load_n : n_q;
        out_d    = run && (cnt_q < {1'b0, n_q});
        cnt_d    = '0;
        if (!load && run && !boundary) begin
            cnt_d = cnt_q + {{NW{1'b0}}, 1'b1};
        end
    end

    // Counter, applied N and divided-clock registers.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            cnt_q <= '0;
            n_q   <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            n_q   <= n_d;
            out_q <= out_d;
        end
    end

    assign out_clk = out_q;
    assign cur_n   = n_q;

endmodule

// File: rtl/clk_div_sched.sv
// clk_div_sched: round-robin arbitrated divide-ratio changes applied
// only at period boundaries. Option: CLK_DIV_SCHED_PERIOD_CNT_EN.
`timescale 1ns/1ps
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int NW      = NW_DEF
) (
    input  logic                  i_clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*NW-1:0] req_n,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  out_clk,
    output logic [NW-1:0]         cur_n,
    output logic                  busy
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    ,
    output logic [PCNT_W-1:0]     period_cnt
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NW-1:0]      pend_q, pend_d;
    logic               busy_q, busy_d;
    logic [PW-1:0]      ptr_q, ptr_d;

    logic               found;
    logic [PW-1:0]      win;
    logic [PW:0]        idx, nxt;
    logic [NW-1:0]      win_n;
    logic               accept;
    logic               load;
    logic [NW-1:0]      load_n;
    logic               run;
    logic               boundary;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_REQ)) begin
                idx = idx - (PW+1)'(NUM_REQ);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
        nxt = {1'b0, win} + {{PW{1'b0}}, 1'b1};
        if (nxt == (PW+1)'(NUM_REQ)) begin
            nxt = '0;
        end
        win_n = req_n[int'(win)*NW +: NW];
    end

    // The ack cycle is skipped so a request still held while its ack
    // is visible is not granted twice for the same change.
    assign accept = found && (ack_q == '0) && (state_q != PEND);
    assign run    = (state_q != IDLE);

    // FSM next state, grant and divider load control.
    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        pend_d  = pend_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        load_n  = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ack_d[win] = 1'b1;
                    ptr_d      = nxt[PW-1:0];
                    if (win_n != '0) begin
                        load    = 1'b1;
                        load_n  = win_n;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    ack_d[win] = 1'b1;
                    ptr_d      = nxt[PW-1:0];
                    pend_d     = win_n;
                    busy_d     = 1'b1;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    load    = 1'b1;
                    load_n  = pend_q;
                    pend_d  = '0;
                    busy_d  = 1'b0;
                    state_d = (pend_q == '0) ? IDLE : RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and arbitration state registers.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= '0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

    clk_div_core #(
        .NW(NW)
    ) u_core (
        .i_clk   (i_clk),
        .rst     (rst),
        .load    (load),
        .load_n  (load_n),
        .run     (run),
        .out_clk (out_clk),
        .boundary(boundary),
        .cur_n   (cur_n)
    );

    assign ack  = ack_q;
    assign busy = busy_q;

`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

    // Completed periods since the last ratio change, saturating.
    always_comb begin
        pcnt_d = pcnt_q;
        if (load && (load_n != cur_n)) begin
            pcnt_d = '0;
        end else if (boundary && (pcnt_q != '1)) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    // Period count register.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign period_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: directed checks of clk_div_sched with hand-computed
// expectations; period_cnt checks under CLK_DIV_SCHED_PERIOD_CNT_EN.
`timescale 1ns/1ps
module tb_clk_div_sched;
    import clk_div_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [7:0] req_n;
    logic [1:0] ack;
    logic       out_clk;
    logic [3:0] cur_n;
    logic       busy;
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    clk_div_sched #(
        .NUM_REQ(2),
        .NW(4)
    ) dut (
        .i_clk  (clk),
        .rst    (rst),
        .req    (req),
        .req_n  (req_n),
        .ack    (ack),
        .out_clk(out_clk),
        .cur_n  (cur_n),
        .busy   (busy)
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_n(input int i, input logic [3:0] v);
        req_n[i*4 +: 4] = v;
    endtask

    task automatic wait_busy_low(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        if (busy !== 1'b0) begin
            chk({tag, "_timeout"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        req_n = '0;
        step();
        step();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_out", 32'(out_clk), 32'd0);
        chk("rst_curn", 32'(cur_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // N=0 accepted from IDLE: ack only
        req = 2'b01;
        set_n(0, 4'd0);
        step();
        chk("n0_ack", 32'(ack), 32'd1);
        chk("n0_curn", 32'(cur_n), 32'd0);
        chk("n0_state", 32'(dut.state_q), 32'(IDLE));
        req = '0;
        step();

        // req[0] N=3: pattern 1,1,1,0,0,0
        req = 2'b01;
        set_n(0, 4'd3);
        step();
        chk("n3_ack", 32'(ack), 32'd1);
        chk("n3_curn", 32'(cur_n), 32'd3);
        chk("n3_out0", 32'(out_clk), 32'd0);
        req = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("n3_pat", 32'(out_clk), 32'((k % 6) < 3));
        end
        chk("n3_ack_gone", 32'(ack), 32'd0);

        // req[1] N=2 sampled at cnt=1
        step();
        req = 2'b10;
        set_n(1, 4'd2);
        step();
        chk("chg_ack", 32'(ack), 32'd2);
        chk("chg_busy", 32'(busy), 32'd1);
        chk("chg_out", 32'(out_clk), 32'd1);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("chg_pend_busy", 32'(busy), 32'd1);
            chk("chg_pend_curn", 32'(cur_n), 32'd3);
            chk("chg_pend_out", 32'(out_clk), 32'(k == 0));
        end
        step();
        chk("chg_done_busy", 32'(busy), 32'd0);
        chk("chg_done_curn", 32'(cur_n), 32'd2);
        chk("chg_done_out", 32'(out_clk), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("n2_pat", 32'(out_clk), 32'((k % 4) < 2));
        end

        // switch to N=4, then request N=0
        req = 2'b01;
        set_n(0, 4'd4);
        step();
        chk("n4_ack", 32'(ack), 32'd1);
        req = '0;
        wait_busy_low("n4");
        chk("n4_curn", 32'(cur_n), 32'd4);
        chk("n4_out", 32'(out_clk), 32'd0);
        req = 2'b01;
        set_n(0, 4'd0);
        step();
        chk("stop_ack", 32'(ack), 32'd1);
        chk("stop_out", 32'(out_clk), 32'd1);
        req = '0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("stop_out_seq", 32'(out_clk), 32'(k < 3));
            chk("stop_busy", 32'(busy), 32'(k < 6));
        end
        chk("stop_curn", 32'(cur_n), 32'd0);
        chk("stop_state", 32'(dut.state_q), 32'(IDLE));
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stop_idle_out", 32'(out_clk), 32'd0);
        end

        // reset while PEND
        req = 2'b01;
        set_n(0, 4'd3);
        step();
        chk("rp_ack0", 32'(ack), 32'd1);
        req = '0;
        step();
        req = 2'b10;
        set_n(1, 4'd5);
        step();
        chk("rp_ack1", 32'(ack), 32'd2);
        req = '0;
        step();
        chk("rp_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("rp_ack", 32'(ack), 32'd0);
        chk("rp_out", 32'(out_clk), 32'd0);
        chk("rp_curn", 32'(cur_n), 32'd0);
        chk("rp_bsy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("rp_curn_hold", 32'(cur_n), 32'd0);
            chk("rp_out_hold", 32'(out_clk), 32'd0);
            chk("rp_ack_hold", 32'(ack), 32'd0);
        end

        // tie from IDLE, then requester 1, then tie again
        req = 2'b11;
        set_n(0, 4'd2);
        set_n(1, 4'd3);
        step();
        chk("tie_ack0", 32'(ack), 32'd1);
        chk("tie_curn", 32'(cur_n), 32'd2);
        req = 2'b10;
        step();
        chk("tie_gap", 32'(ack), 32'd0);
        step();
        chk("tie_ack1", 32'(ack), 32'd2);
        chk("tie_busy", 32'(busy), 32'd1);
        req = '0;
        step();
        chk("tie_pend_curn", 32'(cur_n), 32'd2);
        step();
        chk("tie_applied", 32'(cur_n), 32'd3);
        chk("tie_busy_clr", 32'(busy), 32'd0);
        req = 2'b11;
        set_n(0, 4'd1);
        set_n(1, 4'd1);
        step();
        chk("tie2_ack0", 32'(ack), 32'd1);
        req = '0;
        step();

`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("pc_rst", 32'(period_cnt), 32'd0);
        req = 2'b01;
        set_n(0, 4'd2);
        step();
        req = '0;
        chk("pc_start", 32'(period_cnt), 32'd0);
        for (int k = 0; k < 40; k++) begin
            step();
        end
        chk("pc_ten", 32'(period_cnt), 32'd10);
        req = 2'b10;
        set_n(1, 4'd3);
        step();
        req = '0;
        chk("pc_pend", 32'(period_cnt), 32'd10);
        wait_busy_low("pc");
        chk("pc_clr", 32'(period_cnt), 32'd0);
        chk("pc_curn", 32'(cur_n), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_sched.md
CLK_DIV_SCHED -- requirements
Module: clk_div_sched

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter NW, default 4, giving the width of a divide value N; legal N is 0..2^NW-1.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, NUM_REQ bits: per-requester change request, held until acked.
REQ-006 The block SHALL have port req_n, input, NUM_REQ*NW bits: requested N per requester; slice i is [i*NW +: NW].
REQ-007 The block SHALL have port ack, output, NUM_REQ bits: one-cycle, one-hot acceptance pulse.
REQ-008 The block SHALL have port out_clk, output, 1 bit: divided clock, high N cycles then low N cycles.
REQ-009 The block SHALL have port cur_n, output, NW bits: the N currently applied to the divider.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an accepted N is waiting for a period boundary.

Function
REQ-011 The block SHALL have FSM states IDLE (divider stopped, out_clk=0), RUN (dividing by 2*cur_n) and PEND (running, new N latched in pend_n).
REQ-012 The block SHALL run an internal counter cnt from 0 to 2*cur_n-1 in RUN and PEND; it wraps to 0 after 2*cur_n-1.
REQ-013 The block SHALL register out_clk; out_clk(t+1) = (cnt(t) < cur_n) in RUN and PEND, and 0 in IDLE.
REQ-014 The period boundary SHALL be defined as the cycle with cnt == 2*cur_n-1.
REQ-015 Arbitration SHALL be round-robin starting at the index after the last acked requester; after reset the priority pointer is 0.
REQ-016 Acceptance SHALL occur only in IDLE or RUN; no request is accepted in PEND.
REQ-017 On acceptance the winner's ack SHALL pulse high for exactly one cycle, in the cycle after req was sampled.
REQ-018 Acceptance in IDLE with N>0 SHALL load cur_n=N and cnt=0 and go to RUN; out_clk rises one cycle later.
REQ-019 Acceptance in IDLE with N=0 SHALL produce an ack with no state change.
REQ-020 Acceptance in RUN SHALL latch pend_n, set busy=1 and go to PEND.
REQ-021 In PEND at the boundary, the block SHALL load cur_n=pend_n and cnt=0 and clear busy. If pend_n=0 it goes to IDLE with cur_n=0; otherwise it goes to RUN.
REQ-022 Acceptance in RUN coinciding with a boundary SHALL take the PEND path, applying the change at the next boundary (no mid-cycle shortening).
REQ-023 Requests withdrawn before ack SHALL be ignored; req held after ack SHALL be treated as a new request.
REQ-024 cur_n SHALL change only at boundaries or on IDLE acceptance, so no out_clk phase is shorter than min(old N, new N) cycles.

Reset
REQ-025 In any state, rst SHALL set the FSM to IDLE, cnt=0, cur_n=0, pend_n=0, out_clk=0, ack=0, busy=0 and the priority pointer to 0 on the next edge.
REQ-026 Reset mid-PEND SHALL discard pend_n with no ack re-issued.

Configuration
REQ-027 With macro CLK_DIV_SCHED_PERIOD_CNT_EN defined, the block SHALL add output period_cnt (16 bits). It counts completed periods (boundaries in RUN/PEND), saturates at 0xFFFF, and clears on reset or any cur_n change.
REQ-028 Without CLK_DIV_SCHED_PERIOD_CNT_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package clk_div_pkg SHALL hold the FSM state enum (IDLE, RUN, PEND) and the default NW/NUM_REQ constants.
REQ-030 The counter and out_clk generation SHALL be sub-module clk_div_core (inputs: load, load_n, run; outputs: out_clk, boundary). Arbitration and the FSM remain in clk_div_sched.

Verification
REQ-031 Bench SHALL cover: reset, then req[0] with N=3 -> ack[0] pulse; out_clk pattern 1,1,1,0,0,0 repeating; cur_n=3.
REQ-032 Bench SHALL cover: running N=3, req[1] with N=2 at cnt=1 -> busy=1 until the boundary, then period 4 (2 high, 2 low); no truncated phase.
REQ-033 Bench SHALL cover: req[0] and req[1] asserted together from IDLE -> ack[0] first. Then, after the boundary, ack[1]; the next tie goes to requester 0.
REQ-034 Bench SHALL cover: running N=4, request N=0 -> out_clk completes its low phase, then stays 0; FSM is IDLE; cur_n=0.
REQ-035 Bench SHALL cover: rst asserted in PEND -> all outputs 0 next cycle; the latched N is never applied.
REQ-036 Bench SHALL cover, with CLK_DIV_SCHED_PERIOD_CNT_EN: N=2 for 10 periods -> period_cnt=10; after a ratio change -> 0.
